rx_frame_sequencer: RTL

//  Frame-level controller on the RX FIFO read pipe. Pops 10-bit entries {tlast,tdata[7:0],tkeep}
//  and forwards them to the NIC byte pipe through a 1-entry output register. Counts bytes per

---
 rtl/rx_frame_sequencer_if.sv | 30 +++
 rtl/rx_frame_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rx_frame_sequencer_if : FIFO read, byte-out and status handshakes|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface rx_frame_sequencer_if #(
  parameter int ENTRY_W = 10,
  parameter int LEN_W   = 16
) ();
  logic [ENTRY_W-1:0] fifo_read_data;
  logic               fifo_read_ack;
  logic               fifo_read_req;
  logic [ENTRY_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [LEN_W:0]     status_data;
  logic               status_valid;
  logic               status_ready;

  modport master (
    input  fifo_read_data, fifo_read_ack, out_ready, status_ready,
    output fifo_read_req, out_data, out_valid, status_data, status_valid
  );

  modport slave (
    output fifo_read_data, fifo_read_ack, out_ready, status_ready,
    input  fifo_read_req, out_data, out_valid, status_data, status_valid
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rx_frame_sequencer : RX FIFO frame forwarder with truncation,    |
// | per-frame status word and saturating frame counters. rev 1.0     |
// +------------------------------------------------------------------+
module rx_frame_sequencer #(
  parameter int ENTRY_W   = 10,
  parameter int LEN_W     = 16,
  parameter int MAX_FRAME = 1518
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  rx_frame_sequencer_if.master bus,
  output logic                 busy,
  output logic [15:0]          frames_ok,
  output logic [15:0]          frames_trunc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS   = 2'd1,
    DRAIN  = 2'd2,
    STATUS = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);

  state_t             state;
  state_t             state_nxt;
  logic               read_req;
  logic               pop;
  logic               status_take;
  logic               entry_last;
  logic               entry_keep;
  logic               hit_max;
  logic [LEN_W-1:0]   byte_cnt;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ENTRY_W-1:0] out_data_r;
  logic               out_valid_r;
  logic [LEN_W:0]     status_data_r;
  logic               status_valid_r;

  assign entry_last  = bus.fifo_read_data[ENTRY_W-1];
  assign entry_keep  = bus.fifo_read_data[0];
  assign cnt_inc     = byte_cnt + {{(LEN_W-1){1'b0}}, entry_keep};
  assign hit_max     = (cnt_inc == MAX_LEN);
  assign pop         = read_req & bus.fifo_read_ack;
  assign status_take = status_valid_r & bus.status_ready;

  assign bus.fifo_read_req = read_req;
  assign bus.out_data      = out_data_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.status_data   = status_data_r;
  assign bus.status_valid  = status_valid_r;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request in PASS depends only on the output register, never on ack.
  always_comb begin
    state_nxt = state;
    read_req  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = PASS;
      end
      PASS: begin
        read_req = !out_valid_r | bus.out_ready;
        if (read_req && bus.fifo_read_ack) begin
          if (entry_last)   state_nxt = STATUS;
          else if (hit_max) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        read_req = 1'b1;
        if (bus.fifo_read_ack && entry_last) state_nxt = STATUS;
      end
      STATUS: begin
        if (status_take) state_nxt = enable ? PASS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r     <= '0;
      out_valid_r    <= 1'b0;
      status_data_r  <= '0;
      status_valid_r <= 1'b0;
      byte_cnt       <= '0;
      frames_ok      <= '0;
      frames_trunc   <= '0;
    end else begin
      if (state == PASS && pop) begin
        out_valid_r <= 1'b1;
        byte_cnt    <= cnt_inc;
        // The entry that reaches the limit closes the forwarded frame.
        if (!entry_last && hit_max)
          out_data_r <= {1'b1, bus.fifo_read_data[ENTRY_W-2:0]};
        else
          out_data_r <= bus.fifo_read_data;
        if (entry_last) begin
          status_valid_r <= 1'b1;
          status_data_r  <= {1'b0, cnt_inc};
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (state == DRAIN && pop && entry_last) begin
        status_valid_r <= 1'b1;
        status_data_r  <= {1'b1, byte_cnt};
      end

      if (status_take) begin
        status_valid_r <= 1'b0;
        byte_cnt       <= '0;
        if (status_data_r[LEN_W]) begin
          if (frames_trunc != 16'hFFFF) frames_trunc <= frames_trunc + 16'd1;
        end else begin
          if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
